// File: rtl/sevenseg_pkg.sv
// Shared types and the code-to-segment decode table for the 7-segment scan driver.
// Segment patterns are active-low: bit 7 = dp, bits 6:0 = g..a.
package sevenseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_MINUS = 8'hBF;

  // Codes 10-15 are hex letters when hex_mode is set; otherwise 10 is '-' and 11-15 are dark.
  function automatic seg_t seg_decode(input logic [3:0] code, input logic hex_mode);
    seg_t seg;
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h98;
      4'hA: seg = hex_mode ? 8'h88 : SEG_MINUS;
      4'hB: seg = hex_mode ? 8'h83 : SEG_BLANK;
      4'hC: seg = hex_mode ? 8'hC6 : SEG_BLANK;
      4'hD: seg = hex_mode ? 8'hA1 : SEG_BLANK;
      4'hE: seg = hex_mode ? 8'h86 : SEG_BLANK;
      4'hF: seg = hex_mode ? 8'h8E : SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Host-side bus of the scan driver: load strobe with digit/dp/blank vectors in,
// multiplexed segment and digit-select pins out.
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import sevenseg_pkg::*;

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  seg_t                      leds;
  logic [NUM_DIGITS-1:0]     digit_en;

  modport master (
    output load, digits_in, dp_in, blank_in,
    input  leds, digit_en
  );

  modport slave (
    input  load, digits_in, dp_in, blank_in,
    output leds, digit_en
  );

endinterface

// File: rtl/sevenseg_decode.sv
// Combinational decode of one digit: code plus dp, with a blank request overriding
// everything (dp included).
module sevenseg_decode
  import sevenseg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] code,
  input  logic       dp,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = seg_decode(code, HEX_MODE != 0);
    if (dp)
      seg[7] = 1'b0;
    if (blank)
      seg = SEG_BLANK;
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow-latched digits, per-slot dwell with
// leading dead-time, registered outputs that go dark asynchronously on reset.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 12500,
  parameter int DEAD_CYCLES = 16,
  parameter int HEX_MODE    = 0,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sevenseg_scan_driver_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_BASE    = NUM_DIGITS'(1);

  logic [PW-1:0]           presc_reg, presc_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
  logic [NUM_DIGITS-1:0]   dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
  seg_t                    pattern_reg, pattern_next;
  seg_t                    leds_reg, leds_next;
  logic [NUM_DIGITS-1:0]   en_reg, en_next;
  logic                    slot_wrap;
  logic                    in_dead;

  logic [NUM_DIGITS:0]     zero_run;
  logic [NUM_DIGITS-1:0]   lz_mask;
  seg_t                    digit_seg [NUM_DIGITS];

  assign digits_next = bus.load ? bus.digits_in : digits_reg;
  assign dp_next     = bus.load ? bus.dp_in     : dp_reg;
  assign blank_next  = bus.load ? bus.blank_in  : blank_reg;

  // Decoding works on the shadow as it will stand during the next cycle, so the
  // pattern registered on entry to a slot matches the shadow seen in that slot's
  // first cycle; a load in that same cycle lands one edge too late to affect it.
  // zero_run[i] is true when digit i and everything above it is 0 with no dp set.
  assign zero_run[NUM_DIGITS] = (LZ_BLANK != 0);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign zero_run[gi] = zero_run[gi+1] && (digits_next[4*gi +: 4] == 4'd0) && !dp_next[gi];
    assign lz_mask[gi]  = (gi != 0) && zero_run[gi];

    sevenseg_decode #(
      .HEX_MODE (HEX_MODE)
    ) u_decode (
      .code  (digits_next[4*gi +: 4]),
      .dp    (dp_next[gi]),
      .blank (blank_next[gi] | lz_mask[gi]),
      .seg   (digit_seg[gi])
    );
  end

  always_comb begin
    slot_wrap  = (presc_reg == PRESC_LAST);
    presc_next = slot_wrap ? '0 : presc_reg + 1'b1;
    idx_next   = idx_reg;
    if (slot_wrap)
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

    pattern_next = (presc_next == '0) ? digit_seg[idx_next] : pattern_reg;
    in_dead      = (DEAD_CYCLES > 0) && (int'(presc_next) < DEAD_CYCLES);
    leds_next    = in_dead ? SEG_BLANK : pattern_next;
    en_next      = in_dead ? '0 : (EN_BASE << idx_next);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg   <= '0;
      idx_reg     <= '0;
      digits_reg  <= '0;
      dp_reg      <= '0;
      blank_reg   <= '1;
      pattern_reg <= SEG_BLANK;
      leds_reg    <= SEG_BLANK;
      en_reg      <= '0;
    end else begin
      presc_reg   <= presc_next;
      idx_reg     <= idx_next;
      digits_reg  <= digits_next;
      dp_reg      <= dp_next;
      blank_reg   <= blank_next;
      pattern_reg <= pattern_next;
      leds_reg    <= leds_next;
      en_reg      <= en_next;
    end
  end

  assign bus.leds     = leds_reg;
  assign bus.digit_en = en_reg;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: two instances (decimal and hex decode) driven in
// lockstep and compared every cycle against a time-indexed display model.
module tb_sevenseg_scan_driver;
  import sevenseg_pkg::*;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;

  localparam logic [7:0] DEC_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};
  localparam logic [7:0] HEX_TAB [6]  = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();
  sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .HEX_MODE(0), .LZ_BLANK(1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .HEX_MODE(1), .LZ_BLANK(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  logic [15:0] sh_d, snap_d;
  logic [3:0]  sh_dp, sh_bl, snap_dp, snap_bl;

  // What digit i should show for a given shadow content.
  function automatic logic [7:0] model_seg(input logic [15:0] d, input logic [3:0] dp,
                                           input logic [3:0] bl, input int i, input bit hex);
    logic [3:0] code;
    logic [7:0] seg;
    bit lz;
    code = d[4*i +: 4];
    if (bl[i]) return 8'hFF;
    lz = (i >= 1);
    for (int k = i; k < ND; k++)
      if (d[4*k +: 4] != 4'd0 || dp[k]) lz = 1'b0;
    if (lz) return 8'hFF;
    if (code < 4'd10)  seg = DEC_TAB[code];
    else if (hex)      seg = HEX_TAB[code - 4'd10];
    else               seg = (code == 4'd10) ? 8'hBF : 8'hFF;
    if (dp[i]) seg[7] = 1'b0;
    return seg;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    sh_d    = 16'h0000;
    sh_dp   = 4'h0;
    sh_bl   = 4'hF;
    snap_d  = sh_d;
    snap_dp = sh_dp;
    snap_bl = sh_bl;
  endtask

  // One clock cycle: check outputs for cycle t, present inputs, advance the model.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl);
    int p, idx;
    logic [7:0] e0, e1;
    logic [3:0] een;
    if (t % SD == 0) begin
      snap_d  = sh_d;
      snap_dp = sh_dp;
      snap_bl = sh_bl;
    end
    p   = t % SD;
    idx = (t / SD) % ND;
    if (p < DC) begin
      e0 = 8'hFF; e1 = 8'hFF; een = 4'h0;
    end else begin
      een = 4'(1 << idx);
      e0  = model_seg(snap_d, snap_dp, snap_bl, idx, 1'b0);
      e1  = model_seg(snap_d, snap_dp, snap_bl, idx, 1'b1);
    end
    check("leds_dec", bus0.leds, e0);
    check("en_dec",   {4'h0, bus0.digit_en}, {4'h0, een});
    check("leds_hex", bus1.leds, e1);
    check("en_hex",   {4'h0, bus1.digit_en}, {4'h0, een});

    bus0.load = ld; bus0.digits_in = d; bus0.dp_in = dp; bus0.blank_in = bl;
    bus1.load = ld; bus1.digits_in = d; bus1.dp_in = dp; bus1.blank_in = bl;
    if (ld) begin
      sh_d  = d;
      sh_dp = dp;
      sh_bl = bl;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic run_to(input int phase, input int period);
    while (t % period != phase) cycle(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rdp, rbl;

    reset_n = 1'b0;
    bus0.load = 1'b0; bus0.digits_in = '0; bus0.dp_in = '0; bus0.blank_in = '0;
    bus1.load = 1'b0; bus1.digits_in = '0; bus1.dp_in = '0; bus1.blank_in = '0;
    model_reset();

    // Held in reset: dark.
    repeat (3) begin
      @(negedge clk);
      check("rst_leds", bus0.leds, 8'hFF);
      check("rst_en",   {4'h0, bus0.digit_en}, 8'h00);
    end
    reset_n = 1'b1;
    model_reset();
    idle(40);

    // Plain digits, then leading-zero cases.
    cycle(1'b1, 16'h1234, 4'h0, 4'h0); idle(70);
    cycle(1'b1, 16'h0070, 4'h0, 4'h0); idle(40);
    cycle(1'b1, 16'h0000, 4'h0, 4'h0); idle(40);
    cycle(1'b1, 16'h0000, 4'b0100, 4'h0); idle(40);

    // Hex/minus codes, blank over dp, dp on a dark code.
    cycle(1'b1, 16'h0FCA, 4'h0, 4'h0); idle(40);
    cycle(1'b1, 16'hDEB9, 4'b0100, 4'h0); idle(40);
    cycle(1'b1, 16'h1234, 4'b0001, 4'b0001); idle(40);

    // Load mid-slot of digit 1, then a load coinciding with a slot start.
    cycle(1'b1, 16'h1234, 4'h0, 4'h0); idle(40);
    run_to(SD + 4, SD * ND);
    cycle(1'b1, 16'h5678, 4'h0, 4'h0); idle(40);
    run_to(2 * SD, SD * ND);
    cycle(1'b1, 16'h4321, 4'h0, 4'h0); idle(40);

    // Asynchronous reset in the middle of a lit slot.
    run_to(5, SD);
    reset_n = 1'b0;
    #1;
    check("async_rst_leds", bus0.leds, 8'hFF);
    check("async_rst_en",   {4'h0, bus0.digit_en}, 8'h00);
    check("async_rst_leds_hex", bus1.leds, 8'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle(1'b1, 16'h8765, 4'h0, 4'h0); idle(40);

    // Random loads biased toward zero nibbles to exercise leading-zero blanking.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < ND; k++)
          rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        rdp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        rbl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        cycle(1'b1, rd, rdp, rbl);
      end else begin
        cycle(1'b0, 16'h0, 4'h0, 4'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
